// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM encoding, IF/ID payload.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // All-zero word doubles as the pipeline bubble.
    localparam word_t NOP_INSTR = '0;

    typedef struct packed {
        word_t instr;
        word_t npc;
        word_t pc;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, npc: '0, pc: '0};

    // Sequential PC; wraps modulo 2^32.
    function automatic word_t pc_plus4(input word_t pc);
        return pc + word_t'(4);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage and its environment.
interface fetch_if
    import cpu_types_pkg::*;
(
    input logic CLK
);
    logic  nRST;
    logic  ihit;
    word_t iload;
    logic  stall_IFID;
    logic  redirect_valid;
    word_t redirect_pc;
    logic  halt;
    logic  imemREN;
    word_t imemaddr;
    word_t instr_out;
    word_t npc_out;
    word_t pc_out;

    modport fs (
        input  CLK, nRST, ihit, iload, stall_IFID, redirect_valid, redirect_pc, halt,
        output imemREN, imemaddr, instr_out, npc_out, pc_out
    );

    modport tb (
        input  CLK, imemREN, imemaddr, instr_out, npc_out, pc_out,
        output nRST, ihit, iload, stall_IFID, redirect_valid, redirect_pc, halt
    );
endinterface

// File: rtl/ifid.sv
// IF/ID pipeline register: load, bubble (flush to NOP) or hold.
module ifid
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load,
    input  logic  bubble,
    input  ifid_t din,
    output ifid_t dout
);

    // Bubble outranks load; neither asserted means hold.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            dout <= IFID_BUBBLE;
        end else if (bubble) begin
            dout <= IFID_BUBBLE;
        end else if (load) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, I-cache request, redirect/halt handling, IF/ID register.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t iload,
    input  logic  stall_IFID,
    input  logic  redirect_valid,
    input  word_t redirect_pc,
    input  logic  halt,
    output logic  imemREN,
    output word_t imemaddr,
    output word_t instr_out,
    output word_t npc_out,
    output word_t pc_out
);

    fetch_state_t state, state_n;
    word_t        pc, pc_n;
    word_t        pend_pc, pend_pc_n;
    logic         ifid_load, ifid_bubble;
    ifid_t        ifid_d, ifid_q;

    // State, PC, pending target and read enable registers.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state   <= RUN;
            pc      <= PC_INIT;
            pend_pc <= '0;
            imemREN <= 1'b1;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            pend_pc <= pend_pc_n;
            imemREN <= (state_n != HALTED);
        end
    end

    // Next-state: a redirect that misses parks in PEND until the miss completes.
    always_comb begin
        state_n = state;
        unique case (state)
            RUN: begin
                if (halt) begin
                    state_n = HALTED;
                end else if (redirect_valid && !ihit) begin
                    state_n = PEND;
                end
            end
            PEND: begin
                if (halt) begin
                    state_n = HALTED;
                end else if (ihit) begin
                    state_n = RUN;
                end
            end
            HALTED: state_n = HALTED;
            default: state_n = RUN;
        endcase
    end

    // PC, pending target and IF/ID control; flush/halt outrank the stall.
    always_comb begin
        pc_n        = pc;
        pend_pc_n   = pend_pc;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        unique case (state)
            RUN: begin
                if (halt) begin
                    ifid_bubble = 1'b1;
                end else if (redirect_valid) begin
                    ifid_bubble = 1'b1;
                    if (ihit) begin
                        pc_n = redirect_pc;
                    end else begin
                        pend_pc_n = redirect_pc;
                    end
                end else if (ihit) begin
                    if (!stall_IFID) begin
                        ifid_load = 1'b1;
                        pc_n      = pc_plus4(pc);
                    end
                end else begin
                    ifid_bubble = 1'b1;
                end
            end
            PEND: begin
                ifid_bubble = 1'b1;
                if (!halt) begin
                    if (redirect_valid) begin
                        pend_pc_n = redirect_pc;
                        if (ihit) begin
                            pc_n = redirect_pc;
                        end
                    end else if (ihit) begin
                        pc_n = pend_pc;
                    end
                end
            end
            default: ;
        endcase
    end

    assign ifid_d = '{instr: iload, npc: pc_plus4(pc), pc: pc};

    ifid u_ifid (
        .CLK    (CLK),
        .nRST   (nRST),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .din    (ifid_d),
        .dout   (ifid_q)
    );

    assign imemaddr  = pc;
    assign instr_out = ifid_q.instr;
    assign npc_out   = ifid_q.npc;
    assign pc_out    = ifid_q.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a behavioural fetch model.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    localparam word_t PC_INIT = 32'h0000_0000;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  ihit, stall_IFID, redirect_valid, halt;
    word_t iload, redirect_pc;
    logic  imemREN;
    word_t imemaddr, instr_out, npc_out, pc_out;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model of the fetch stage's architectural state.
    word_t m_pc, m_target, m_instr, m_npc, m_pcout;
    bit    m_waiting, m_stopped;

    always #5 CLK = ~CLK;

    fetch_if fif (.CLK(CLK));

    assign fif.nRST           = nRST;
    assign fif.ihit           = ihit;
    assign fif.iload          = iload;
    assign fif.stall_IFID     = stall_IFID;
    assign fif.redirect_valid = redirect_valid;
    assign fif.redirect_pc    = redirect_pc;
    assign fif.halt           = halt;
    assign imemREN   = fif.imemREN;
    assign imemaddr  = fif.imemaddr;
    assign instr_out = fif.instr_out;
    assign npc_out   = fif.npc_out;
    assign pc_out    = fif.pc_out;

    fetch_stage #(.PC_INIT(PC_INIT)) dut (
        .CLK            (fif.CLK),
        .nRST           (fif.nRST),
        .ihit           (fif.ihit),
        .iload          (fif.iload),
        .stall_IFID     (fif.stall_IFID),
        .redirect_valid (fif.redirect_valid),
        .redirect_pc    (fif.redirect_pc),
        .halt           (fif.halt),
        .imemREN        (fif.imemREN),
        .imemaddr       (fif.imemaddr),
        .instr_out      (fif.instr_out),
        .npc_out        (fif.npc_out),
        .pc_out         (fif.pc_out)
    );

    // Instruction memory contents: a scrambled function of the address.
    function automatic word_t mem_word(input word_t a);
        return ((a ^ 32'h5A5A_1234) * 32'h0001_0DCD) | 32'h0000_0001;
    endfunction

    function automatic void model_reset();
        m_pc = PC_INIT; m_target = '0; m_waiting = 0; m_stopped = 0;
        m_instr = '0; m_npc = '0; m_pcout = '0;
    endfunction

    function automatic void model_flush();
        m_instr = '0; m_npc = '0; m_pcout = '0;
    endfunction

    // One rising edge of the fetch stage, written from the operational rules.
    function automatic void model_edge();
        if (m_stopped) return;
        if (halt) begin
            m_stopped = 1;
            model_flush();
        end else if (m_waiting) begin
            model_flush();
            if (redirect_valid) m_target = redirect_pc;
            if (ihit) begin
                m_pc = redirect_valid ? redirect_pc : m_target;
                m_waiting = 0;
            end
        end else if (redirect_valid) begin
            model_flush();
            if (ihit) m_pc = redirect_pc;
            else begin
                m_target = redirect_pc;
                m_waiting = 1;
            end
        end else if (ihit) begin
            if (!stall_IFID) begin
                m_instr = mem_word(m_pc);
                m_npc   = m_pc + 32'd4;
                m_pcout = m_pc;
                m_pc    = m_pc + 32'd4;
            end
        end else begin
            model_flush();
        end
    endfunction

    task automatic idle_inputs();
        ihit = 0; stall_IFID = 0; redirect_valid = 0; halt = 0; redirect_pc = '0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle_inputs();
        nRST = 0;
        model_reset();
        @(negedge CLK);
        nRST = 1;
        iload = mem_word(m_pc);
    endtask

    // Advance one edge; leaves the bench 1 time unit after the edge.
    task automatic cyc();
        @(posedge CLK);
        model_edge();
        #1;
        iload = mem_word(m_pc);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({imemREN, imemaddr, instr_out, npc_out, pc_out} !== {1'b1, PC_INIT, 96'b0}) begin
            n_bad++;
            $display("FAIL reset_values: got ren=%b addr=%h ifid=%h/%h/%h expected ren=1 addr=%h ifid=0",
                     imemREN, imemaddr, instr_out, npc_out, pc_out, PC_INIT);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ihit = 1;
            n_vec++;
            if (imemaddr !== word_t'(4 * i)) begin
                n_bad++;
                $display("FAIL seq_addr[%0d]: got %h expected %h", i, imemaddr, word_t'(4 * i));
            end
            cyc();
            n_vec++;
            if ({instr_out, npc_out, pc_out} !== {mem_word(word_t'(4 * i)), word_t'(4 * i + 4), word_t'(4 * i)}) begin
                n_bad++;
                $display("FAIL seq_ifid[%0d]: got %h/%h/%h expected %h/%h/%h", i, instr_out, npc_out, pc_out,
                         mem_word(word_t'(4 * i)), word_t'(4 * i + 4), word_t'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        ihit = 1;
        cyc();
        cyc();
        stall_IFID = 1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_vec++;
            if ({imemaddr, instr_out, npc_out, pc_out} !== {32'h8, mem_word(32'h4), 32'h8, 32'h4}) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got addr=%h ifid=%h/%h/%h expected addr=8 ifid=%h/8/4",
                         i, imemaddr, instr_out, npc_out, pc_out, mem_word(32'h4));
            end
        end
        stall_IFID = 0;
        cyc();
        n_vec++;
        if ({instr_out, pc_out, imemaddr} !== {mem_word(32'h8), 32'h8, 32'hC}) begin
            n_bad++;
            $display("FAIL stall_release: got instr=%h pc=%h addr=%h expected %h/8/c",
                     instr_out, pc_out, imemaddr, mem_word(32'h8));
        end
    endtask

    task automatic test_redirect_hit();
        do_reset();
        ihit = 1;
        for (int i = 0; i < 4; i++) cyc();
        redirect_valid = 1; redirect_pc = 32'h40;
        cyc();
        n_vec++;
        if ({imemaddr, instr_out} !== {32'h40, NOP_INSTR}) begin
            n_bad++;
            $display("FAIL redir_hit_flush: got addr=%h instr=%h expected 40/0", imemaddr, instr_out);
        end
        redirect_valid = 0;
        cyc();
        n_vec++;
        if ({pc_out, instr_out} !== {32'h40, mem_word(32'h40)}) begin
            n_bad++;
            $display("FAIL redir_hit_target: got pc=%h instr=%h expected 40/%h", pc_out, instr_out, mem_word(32'h40));
        end
    endtask

    task automatic test_redirect_miss();
        do_reset();
        ihit = 1; redirect_valid = 1; redirect_pc = 32'h20;
        cyc();
        ihit = 0; redirect_pc = 32'h80;
        cyc();
        n_vec++;
        if ({imemREN, imemaddr, instr_out} !== {1'b1, 32'h20, NOP_INSTR}) begin
            n_bad++;
            $display("FAIL redir_miss_hold: got ren=%b addr=%h instr=%h expected 1/20/0", imemREN, imemaddr, instr_out);
        end
        redirect_pc = 32'h90;
        cyc();
        redirect_valid = 0; ihit = 1;
        cyc();
        n_vec++;
        if ({imemaddr, instr_out} !== {32'h90, NOP_INSTR}) begin
            n_bad++;
            $display("FAIL redir_miss_target: got addr=%h instr=%h expected 90/0", imemaddr, instr_out);
        end
        cyc();
        n_vec++;
        if ({pc_out, instr_out} !== {32'h90, mem_word(32'h90)}) begin
            n_bad++;
            $display("FAIL redir_miss_fetch: got pc=%h instr=%h expected 90/%h", pc_out, instr_out, mem_word(32'h90));
        end
    endtask

    task automatic test_halt();
        do_reset();
        ihit = 1;
        for (int i = 0; i < 3; i++) cyc();
        halt = 1;
        cyc();
        n_vec++;
        if ({imemREN, imemaddr, instr_out} !== {1'b0, 32'hC, NOP_INSTR}) begin
            n_bad++;
            $display("FAIL halt_enter: got ren=%b addr=%h instr=%h expected 0/c/0", imemREN, imemaddr, instr_out);
        end
        for (int i = 0; i < 10; i++) begin
            halt = 1'($urandom_range(0, 1));
            ihit = 1'($urandom_range(0, 1));
            redirect_valid = 1'($urandom_range(0, 1));
            redirect_pc = {$urandom_range(0, 255), 2'b00};
            cyc();
            n_vec++;
            if ({imemREN, imemaddr, instr_out, npc_out, pc_out} !== {1'b0, 32'hC, 96'b0}) begin
                n_bad++;
                $display("FAIL halt_frozen[%0d]: got ren=%b addr=%h ifid=%h/%h/%h expected 0/c/0",
                         i, imemREN, imemaddr, instr_out, npc_out, pc_out);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ihit = 1;
        cyc();
        cyc();
        ihit = 0; redirect_valid = 1; redirect_pc = 32'h200;
        cyc();
        redirect_valid = 0;
        #3;
        nRST = 0;
        model_reset();
        #1;
        n_vec++;
        if ({imemREN, imemaddr, instr_out, npc_out, pc_out} !== {1'b1, PC_INIT, 96'b0}) begin
            n_bad++;
            $display("FAIL async_reset: got ren=%b addr=%h ifid=%h/%h/%h expected 1/%h/0",
                     imemREN, imemaddr, instr_out, npc_out, pc_out, PC_INIT);
        end
        @(negedge CLK);
        nRST = 1;
        ihit = 1;
        iload = mem_word(m_pc);
        cyc();
        n_vec++;
        if ({pc_out, instr_out, imemaddr} !== {PC_INIT, mem_word(PC_INIT), PC_INIT + 32'd4}) begin
            n_bad++;
            $display("FAIL async_reset_run: got pc=%h instr=%h addr=%h expected %h/%h/%h",
                     pc_out, instr_out, imemaddr, PC_INIT, mem_word(PC_INIT), PC_INIT + 32'd4);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        ihit = 1; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 0;
        cyc();
        n_vec++;
        if ({npc_out, pc_out, imemaddr} !== {32'h0, 32'hFFFF_FFFC, 32'h0}) begin
            n_bad++;
            $display("FAIL pc_wrap: got npc=%h pc=%h addr=%h expected 0/fffffffc/0", npc_out, pc_out, imemaddr);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (m_stopped && ($urandom_range(0, 7) == 0)) do_reset();
            halt           = ($urandom_range(0, 119) == 0);
            redirect_valid = ($urandom_range(0, 5) == 0);
            redirect_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            ihit           = ($urandom_range(0, 3) != 0);
            stall_IFID     = ($urandom_range(0, 3) == 0);
            cyc();
            n_vec++;
            if ({imemREN, imemaddr, instr_out, npc_out, pc_out} !== {~m_stopped, m_pc, m_instr, m_npc, m_pcout}) begin
                n_bad++;
                $display("FAIL random[%0d]: got ren=%b addr=%h ifid=%h/%h/%h expected ren=%b addr=%h ifid=%h/%h/%h",
                         i, imemREN, imemaddr, instr_out, npc_out, pc_out,
                         ~m_stopped, m_pc, m_instr, m_npc, m_pcout);
            end
        end
    endtask

    initial begin
        nRST = 0;
        idle_inputs();
        iload = '0;
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_hit();
        test_redirect_miss();
        test_halt();
        test_async_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline: owns the program counter, drives the instruction-cache request, and holds the IF/ID pipeline register that feeds decode and, through it, the ID/EX latch. Advances only on `ihit`. Handles stalls from the hazard unit, control-flow redirects from EX (including redirects that arrive during an I-cache miss), and halt.

## Interface
Parameters:
- `PC_INIT`, `32'h0000_0000`: PC value after reset.

Ports:
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `ihit` in 1: I-cache returns `iload` this cycle.
- `iload` in 32: instruction word for `imemaddr`.
- `stall_IFID` in 1: hazard-unit stall; hold PC and IF/ID.
- `redirect_valid` in 1: taken branch, jump or mispredict from EX.
- `redirect_pc` in 32: redirect target, word-aligned.
- `halt` in 1: halt is committed; stop fetching.
- `imemREN` out 1: I-cache read enable.
- `imemaddr` out 32: fetch address, equal to the PC register.
- `instr_out` out 32: IF/ID instruction.
- `npc_out` out 32: IF/ID PC+4.
- `pc_out` out 32: IF/ID PC.

## Operation
- FSM states:
  - RUN: normal fetch.
  - PEND: a redirect is latched while a miss is outstanding.
  - HALTED: fetch stopped.
- Reset values:
  - State RUN; PC = `PC_INIT`; `pend_pc` = 0.
  - `instr_out`, `npc_out`, `pc_out` = 0. An all-zero instruction is the bubble/NOP.
  - `imemREN` = 1.
- `imemaddr` = PC in every state. The address stays stable during a miss and never changes while `ihit`=0.
- `imemREN` = 1 in RUN and PEND, 0 in HALTED.
- RUN, at the rising edge, evaluated in priority order:
  1. `halt`: go to HALTED; IF/ID loads the bubble; PC holds.
  2. `redirect_valid` & `ihit`: PC <= `redirect_pc`; IF/ID loads the bubble, because the fetched word is wrong-path.
  3. `redirect_valid` & !`ihit`: `pend_pc` <= `redirect_pc`; go to PEND; IF/ID loads the bubble; PC holds.
  4. `ihit` & `stall_IFID`: PC and IF/ID hold; the fetched word is dropped and refetched next cycle.
  5. `ihit`: IF/ID <= {`iload`, PC+4, PC}; PC <= PC+4.
  6. Otherwise (miss): PC holds; IF/ID loads the bubble, so decode sees a NOP while fetch waits.
- PEND, at the rising edge:
  - `halt`: go to HALTED.
  - `redirect_valid`: `pend_pc` <= `redirect_pc`; the newest redirect wins.
  - If `ihit` is also high, PC <= `redirect_pc` directly.
  - `ihit` without a redirect: discard `iload`; PC <= `pend_pc`; go to RUN.
  - IF/ID loads the bubble every cycle in PEND.
- HALTED: all registers hold; only `nRST` leaves this state.
- PC+4 uses 32-bit wrap-around: `32'hFFFF_FFFC` + 4 = 0.
- `stall_IFID` is ignored when a redirect or halt is present: the flush outranks the stall.

## Timing
- Fetch-to-IF/ID latency: 1 edge after `ihit`.
- Back-to-back hits give one instruction per cycle.
- Redirect with hit: the target is on `imemaddr` the cycle after the edge. The first target instruction reaches IF/ID one hit later.
- Redirect during a miss: the target is on `imemaddr` the cycle after the outstanding miss completes.
- `halt`: `imemREN` falls the cycle after the edge where `halt` is sampled.
- Asynchronous reset in any state, including PEND mid-miss: all outputs go to their reset values immediately, and the pending target is lost.

## Structure
- Typedefs and constants come from `cpu_types_pkg`:
  - `word_t` (32-bit).
  - The new `fetch_state_t` enum {RUN, PEND, HALTED}.
  - A `NOP_INSTR` constant (0).
- Interface bundle: add `fetch_if.vh` with modports for the fetch stage and the testbench.
- One sub-module, `ifid`: the IF/ID register with load/hold/bubble controls, structured like the existing ID/EX latch.
- The PC, `pend_pc` and FSM live in `fetch_stage`.

## Test plan
- Reset then `ihit`=1 for 3 cycles with `iload` = A, B, C:
  - `imemaddr` = 0, 4, 8.
  - IF/ID `pc_out` = 0, 4, 8 and `npc_out` = 4, 8, C.
- `ihit`=1 with `stall_IFID`=1 for 2 cycles at PC 8: PC stays 8 and IF/ID is unchanged; release gives `instr_out` = the word at 8.
- Redirect with hit, `redirect_pc` = 0x40 at PC 0x10:
  - The next cycle has `imemaddr` = 0x40 and `instr_out` = 0.
  - The next hit loads `pc_out` = 0x40.
- Redirect to 0x80 during a miss at PC 0x20, a second redirect to 0x90 one cycle later, then `ihit`:
  - The word for 0x20 is discarded.
  - `imemaddr` = 0x90 the cycle after the hit.
- `halt` in RUN:
  - `imemREN`=0 next cycle.
  - PC and IF/ID are frozen for 10 cycles regardless of `ihit` and `redirect_valid`.
- `nRST` pulsed low mid-miss while in PEND: PC = `PC_INIT`, IF/ID = 0 and state RUN, all asynchronously.
